// File: rtl/te_pair_sequencer_if.sv
// Bundle between the BX start/done chain, the pair sequencer and the two VM-stub memories.
// The sequencer drives the slave side; the BX chain / memory side is the master.
interface te_pair_sequencer_if #(
    parameter int BX_BITS  = 5,
    parameter int IDX_BITS = 6
);
    logic [1:0]                  start;
    logic [IDX_BITS-1:0]         number_in_innervmstubin;
    logic [IDX_BITS-1:0]         number_in_outervmstubin;
    logic                        stall;
    logic [BX_BITS+IDX_BITS-1:0] read_add_innervmstubin;
    logic [BX_BITS+IDX_BITS-1:0] read_add_outervmstubin;
    logic                        pair_valid;
    logic                        pair_last;
    logic [1:0]                  done;
    logic                        busy;
    logic                        truncated;
    logic                        overrun;

    modport master (
        output start, number_in_innervmstubin, number_in_outervmstubin, stall,
        input  read_add_innervmstubin, read_add_outervmstubin, pair_valid, pair_last,
               done, busy, truncated, overrun
    );

    modport slave (
        input  start, number_in_innervmstubin, number_in_outervmstubin, stall,
        output read_add_innervmstubin, read_add_outervmstubin, pair_valid, pair_last,
               done, busy, truncated, overrun
    );
endinterface

// File: rtl/te_pair_sequencer.sv
// Per-BX inner x outer pair sequencer: one address pair per cycle, pair_valid/pair_last LOOKUP_LAT cycles later.
// stall holds the addresses and suppresses issue without freezing the valid pipeline; LOOKUP_LAT must be >= 2.
module te_pair_sequencer #(
    parameter int BX_BITS    = 5,
    parameter int IDX_BITS   = 6,
    parameter int MAX_PAIRS  = 108,
    parameter int LOOKUP_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    te_pair_sequencer_if.slave bus
);
    localparam int CNT_BITS  = 12;
    localparam int DRAIN_CYC = LOOKUP_LAT - 1;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ITER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state_q;
    logic [BX_BITS-1:0]    bx_q;
    logic [IDX_BITS-1:0]   inner_q;
    logic [IDX_BITS-1:0]   outer_q;
    logic [IDX_BITS-1:0]   ni_q;
    logic [IDX_BITS-1:0]   no_q;
    logic [CNT_BITS-1:0]   pair_cnt_q;
    logic [DW-1:0]         drain_cnt_q;
    logic [LOOKUP_LAT-1:0] vld_pipe_q;
    logic [LOOKUP_LAT-1:0] last_pipe_q;
    logic                  done0_q;
    logic                  done1_q;
    logic                  busy_q;
    logic                  truncated_q;
    logic                  overrun_q;

    logic issue;
    logic inner_end;
    logic outer_end;
    logic budget_end;
    logic last_pair;

    // A start pulse preempts the issue slot of the cycle it arrives in.
    assign issue      = (state_q == ITER) && !bus.stall && !bus.start[0] && !bus.start[1];
    assign inner_end  = (inner_q == ni_q - IDX_BITS'(1));
    assign outer_end  = (outer_q == no_q - IDX_BITS'(1));
    assign budget_end = (pair_cnt_q == CNT_BITS'(MAX_PAIRS - 1));
    assign last_pair  = (inner_end && outer_end) || budget_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bx_q        <= '1;
            inner_q     <= '0;
            outer_q     <= '0;
            ni_q        <= '0;
            no_q        <= '0;
            pair_cnt_q  <= '0;
            drain_cnt_q <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            truncated_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.start[1]) begin
            state_q     <= IDLE;
            bx_q        <= '1;
            inner_q     <= '0;
            outer_q     <= '0;
            ni_q        <= '0;
            no_q        <= '0;
            pair_cnt_q  <= '0;
            drain_cnt_q <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b1;
            busy_q      <= 1'b0;
            truncated_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            overrun_q   <= 1'b0;
            vld_pipe_q  <= {vld_pipe_q[LOOKUP_LAT-2:0], issue};
            last_pipe_q <= {last_pipe_q[LOOKUP_LAT-2:0], issue && last_pair};

            if (bus.start[0]) begin
                // Any BX still in flight is abandoned; its done is never raised.
                bx_q        <= bx_q + BX_BITS'(1);
                ni_q        <= bus.number_in_innervmstubin;
                no_q        <= bus.number_in_outervmstubin;
                truncated_q <= 1'b0;
                overrun_q   <= (state_q != IDLE);
                busy_q      <= 1'b1;
                state_q     <= LOAD;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    LOAD: begin
                        inner_q     <= '0;
                        outer_q     <= '0;
                        pair_cnt_q  <= '0;
                        drain_cnt_q <= '0;
                        if (ni_q == '0 || no_q == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                    ITER: begin
                        if (issue) begin
                            pair_cnt_q <= pair_cnt_q + CNT_BITS'(1);
                            if (last_pair) begin
                                // Indices stay on the final pair so the addresses hold it.
                                state_q     <= DRAIN;
                                drain_cnt_q <= '0;
                                truncated_q <= !(inner_end && outer_end);
                            end else if (inner_end) begin
                                inner_q <= '0;
                                outer_q <= outer_q + IDX_BITS'(1);
                            end else begin
                                inner_q <= inner_q + IDX_BITS'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done0_q <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.read_add_innervmstubin = {bx_q, inner_q};
    assign bus.read_add_outervmstubin = {bx_q, outer_q};
    assign bus.pair_valid             = vld_pipe_q[LOOKUP_LAT-1];
    assign bus.pair_last              = last_pipe_q[LOOKUP_LAT-1];
    assign bus.done                   = {done1_q, done0_q};
    assign bus.busy                   = busy_q;
    assign bus.truncated              = truncated_q;
    assign bus.overrun                = overrun_q;
endmodule

// File: tb/tb_te_pair_sequencer.sv
// Directed bench for te_pair_sequencer: per-cycle compare against a pair-list model plus literal checks.
module tb_te_pair_sequencer;
    localparam int BXB  = 5;
    localparam int IDXB = 6;
    localparam int MAXP = 108;
    localparam int LAT  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    te_pair_sequencer_if #(.BX_BITS(BXB), .IDX_BITS(IDXB)) bus ();

    te_pair_sequencer #(
        .BX_BITS(BXB), .IDX_BITS(IDXB), .MAX_PAIRS(MAXP), .LOOKUP_LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: each BX is a list of pairs in issue order; issue is allowed from start+2 on every
    // cycle without stall or start; outputs follow from issue cycles plus the fixed latency.
    int cyc = 0;
    int bx_m;
    bit active;
    int en_cyc;
    int done_at;
    int pq[$];
    int iq[$];
    bit trunc_flag;
    bit trunc_m;
    bit e_valid, e_last, e_busy, e_trunc, e_over;
    bit [1:0] e_done;

    // DUT-side observation logs
    int cnt_valid, cnt_last, cnt_done0, cnt_over;
    int last_done_cyc, last_plast_cyc;
    int alog[$];
    int vcyc[$];
    logic [BXB+IDXB-1:0] hin[3];
    logic [BXB+IDXB-1:0] hout[3];

    task automatic model_reset();
        bx_m = 31; active = 0; en_cyc = 0; done_at = -1;
        pq.delete(); iq.delete();
        trunc_flag = 0; trunc_m = 0;
        e_valid = 0; e_last = 0; e_busy = 0; e_trunc = 0; e_over = 0; e_done = 2'b00;
    endtask

    task automatic model_step();
        bit s0, s1, iss, lst, finishing;
        logic [4:0] b;
        logic [5:0] ii, oo;
        int ni, no, n, tgt;
        s0 = bus.start[0];
        s1 = bus.start[1];
        iss = 0; lst = 0;
        if (active && cyc >= en_cyc && pq.size() > 0 && !bus.stall && !s0 && !s1) begin
            iss = 1;
            b  = bx_m[4:0];
            ii = 6'(pq[0] % 64);
            oo = 6'(pq[0] / 64);
            check("issue_addr", {10'd0, bus.read_add_innervmstubin, bus.read_add_outervmstubin},
                  {10'd0, b, ii, b, oo});
            void'(pq.pop_front());
            if (pq.size() == 0) begin
                lst = 1;
                done_at = cyc + LAT;
                trunc_m = trunc_flag;
            end
            iq.push_back(cyc * 2 + int'(lst));
        end
        finishing = active && !s0 && !s1 && (done_at == cyc + 1);
        e_over = s0 && !s1 && e_busy;
        e_done = {s1, finishing};
        if (finishing) active = 0;
        tgt = cyc + 1 - LAT;
        e_valid = 0; e_last = 0;
        while (iq.size() > 0 && iq[0] / 2 < tgt) void'(iq.pop_front());
        if (iq.size() > 0 && iq[0] / 2 == tgt) begin
            e_valid = 1;
            e_last  = iq[0][0];
            void'(iq.pop_front());
        end
        if (s1) begin
            bx_m = 31; active = 0; pq.delete(); iq.delete(); trunc_m = 0;
            e_valid = 0; e_last = 0; done_at = -1;
        end else if (s0) begin
            bx_m = (bx_m + 1) % 32;
            ni = int'(bus.number_in_innervmstubin);
            no = int'(bus.number_in_outervmstubin);
            n = (ni * no > MAXP) ? MAXP : ni * no;
            trunc_flag = (ni * no > MAXP);
            pq.delete();
            for (int k = 0; k < n; k++) pq.push_back((k % ni) + 64 * (k / ni));
            en_cyc = cyc + 2;
            active = 1;
            trunc_m = 0;
            done_at = (n == 0) ? cyc + 1 + LAT : -1;
        end
        e_busy  = s1 ? 1'b0 : (s0 ? 1'b1 : active);
        e_trunc = trunc_m;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            check("pair_valid", {31'd0, bus.pair_valid}, {31'd0, e_valid});
            check("pair_last",  {31'd0, bus.pair_last},  {31'd0, e_last});
            check("done",       {30'd0, bus.done},       {30'd0, e_done});
            check("busy",       {31'd0, bus.busy},       {31'd0, e_busy});
            check("truncated",  {31'd0, bus.truncated},  {31'd0, e_trunc});
            check("overrun",    {31'd0, bus.overrun},    {31'd0, e_over});
            if (bus.pair_valid) begin
                cnt_valid++;
                vcyc.push_back(cyc);
                alog.push_back(int'(hin[2][IDXB-1:0]) + 256 * int'(hout[2][IDXB-1:0]));
            end
            if (bus.pair_last) begin cnt_last++; last_plast_cyc = cyc; end
            if (bus.done[0])   begin cnt_done0++; last_done_cyc = cyc; end
            if (bus.overrun)   cnt_over++;
            hin[2] = hin[1]; hin[1] = hin[0]; hin[0] = bus.read_add_innervmstubin;
            hout[2] = hout[1]; hout[1] = hout[0]; hout[0] = bus.read_add_outervmstubin;
            if (!reset) model_reset();
            else model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cnt_valid = 0; cnt_last = 0; cnt_done0 = 0; cnt_over = 0;
        last_done_cyc = -1; last_plast_cyc = -2;
        alog.delete(); vcyc.delete();
    endtask

    task automatic do_start(input int ni, input int no);
        bus.start = 2'b01;
        bus.number_in_innervmstubin = IDXB'(ni);
        bus.number_in_outervmstubin = IDXB'(no);
        step();
        bus.start = 2'b00;
        bus.number_in_innervmstubin = IDXB'($urandom_range(1, 63));
        bus.number_in_outervmstubin = IDXB'($urandom_range(1, 63));
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0;
        bit seen;
        n0 = cnt_done0;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (cnt_done0 != n0) seen = 1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int bx_of_dut();
        return int'(bus.read_add_innervmstubin[BXB+IDXB-1:IDXB]);
    endfunction

    int ss;
    int exp_t1[6] = '{'h000, 'h001, 'h100, 'h101, 'h200, 'h201};
    int exp_t4[6] = '{'h000, 'h001, 'h002, 'h100, 'h101, 'h102};

    initial begin
        bus.start = 2'b00;
        bus.number_in_innervmstubin = '0;
        bus.number_in_outervmstubin = '0;
        bus.stall = 1'b0;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step();
        check("rst_bx", bx_of_dut(), 31);
        check("rst_outs", {24'd0, bus.pair_valid, bus.pair_last, bus.done, bus.busy,
                           bus.truncated, bus.overrun, 1'b0}, 32'd0);
        check("rst_idx", {26'd0, bus.read_add_innervmstubin[IDXB-1:0]}, 32'd0);

        // 2 x 3 natural loop
        clear_logs();
        ss = cyc + 1;
        do_start(2, 3);
        wait_done(40, "t1");
        check("t1_bx", bx_of_dut(), 0);
        check("t1_nvalid", cnt_valid, 6);
        check("t1_nlast", cnt_last, 1);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_addr%0d", i), (i < alog.size()) ? alog[i] : -1, exp_t1[i]);
        check("t1_done_vs_last", last_done_cyc, last_plast_cyc);
        check("t1_done_time", last_done_cyc - ss, 10);
        check("t1_trunc", {31'd0, bus.truncated}, 32'd0);

        // empty inner list
        clear_logs();
        ss = cyc + 1;
        do_start(0, 5);
        wait_done(20, "t2");
        check("t2_nvalid", cnt_valid, 0);
        check("t2_done_time", last_done_cyc - ss, 4);
        check("t2_busy", {31'd0, bus.busy}, 32'd0);

        // budget cut
        clear_logs();
        do_start(20, 20);
        wait_done(200, "t3");
        check("t3_nvalid", cnt_valid, 108);
        check("t3_lastpair", (alog.size() > 0) ? alog[alog.size()-1] : -1, 'h507);
        check("t3_trunc", {31'd0, bus.truncated}, 32'd1);
        check("t3_hold", {20'd0, bus.read_add_innervmstubin[IDXB-1:0],
                          bus.read_add_outervmstubin[IDXB-1:0]}, {20'd0, 6'd7, 6'd5});

        // stall on issue cycles 2..4
        clear_logs();
        ss = cyc + 1;
        do_start(3, 2);
        repeat (2) step();
        bus.stall = 1'b1;
        step();
        check("t4_held", {20'd0, bus.read_add_innervmstubin[IDXB-1:0],
                          bus.read_add_outervmstubin[IDXB-1:0]}, {20'd0, 6'd1, 6'd0});
        repeat (2) step();
        bus.stall = 1'b0;
        wait_done(40, "t4");
        check("t4_nvalid", cnt_valid, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t4_addr%0d", i), (i < alog.size()) ? alog[i] : -1, exp_t4[i]);
        check("t4_gap", (vcyc.size() > 1) ? vcyc[1] - vcyc[0] : -1, 4);
        check("t4_done_time", last_done_cyc - ss, 13);

        // restart mid-loop
        clear_logs();
        do_start(10, 10);
        repeat (20) step();
        do_start(10, 10);
        check("t5_overrun", {31'd0, bus.overrun}, 32'd1);
        wait_done(200, "t5");
        check("t5_ndone", cnt_done0, 1);
        check("t5_nover", cnt_over, 1);
        check("t5_nvalid", cnt_valid, 119);
        check("t5_bx", bx_of_dut(), 5);

        // pipelined reset mid-loop
        clear_logs();
        do_start(10, 10);
        repeat (5) step();
        bus.start = 2'b11;
        step();
        bus.start = 2'b00;
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_bx", bx_of_dut(), 31);
        check("t6_done", {30'd0, bus.done}, 32'd2);
        repeat (10) step();
        check("t6_ndone0", cnt_done0, 0);

        // bx wraps through 32 BXs
        clear_logs();
        for (int k = 0; k < 32; k++) begin
            do_start(1, 1);
            wait_done(20, "t7");
            if (k == 0) check("t7_wrap", bx_of_dut(), 0);
        end
        check("t7_ndone", cnt_done0, 32);
        check("t7_bx_end", bx_of_dut(), 31);

        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/te_pair_sequencer.md
Name: te_pair_sequencer

Overview:
- Per-BX controller that sequences a tracklet engine's nested inner×outer VM-stub loop.
- On each start pulse it latches the stub counts and issues one (inner, outer) read-address pair per cycle, inner index fastest.
- It honours downstream stall, enforces a per-BX pair budget, and emits a valid flag aligned to memory/lookup latency, plus done and status flags.
- It sits between the BX start/done chain and the two VM-stub memories feeding the TE lookup datapath.

Parameters:
- BX_BITS, 5, width of internal BX counter and upper address bits.
- IDX_BITS, 6, width of stub index and count inputs.
- MAX_PAIRS, 108, maximum pairs issued per BX (cycle budget); range 1..4095.
- LOOKUP_LAT, 3, cycles from address issue to lookup output; pair_valid and pair_last are delayed by this amount.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  2  bit0 = new-BX pulse; bit1 = synchronous pipelined reset.
- number_in_innervmstubin  in  IDX_BITS  inner stub count for the new BX.
- number_in_outervmstubin  in  IDX_BITS  outer stub count for the new BX.
- stall  in  1  downstream backpressure; no new pair is issued while high.
- read_add_innervmstubin  out  BX_BITS+IDX_BITS  {bx, inner_idx}.
- read_add_outervmstubin  out  BX_BITS+IDX_BITS  {bx, outer_idx}.
- pair_valid  out  1  delayed issue strobe, aligned with lookup output.
- pair_last  out  1  delayed marker on the final issued pair of a BX.
- done  out  2  done[0] one-cycle pulse per completed BX; done[1] echoes start[1] delayed one cycle.
- busy  out  1  high in LOAD/ITER/DRAIN.
- truncated  out  1  high from DRAIN entry until next start when the budget cut the loop.
- overrun  out  1  one-cycle pulse when start[0] arrives before done for the current BX.

Behaviour:
- Async reset (reset=0) values:
  - bx = all ones; inner_idx = outer_idx = 0; state = IDLE.
  - All delay stages 0; pair_valid = pair_last = done = busy = truncated = overrun = 0.
- start[1] acts as a synchronous reset of the same registers. It takes priority over start[0] in the same cycle.
- States: IDLE, LOAD, ITER, DRAIN.
- start[0] in any state:
  - Increment bx (wraps all-ones→0), clear truncated, latch both counts, go to LOAD.
  - If the state was LOAD or ITER, or DRAIN before done fires, pulse overrun, drop the old BX's remaining pairs, and issue no done for it.
  - Already-issued pairs in the delay line still emerge.
- LOAD (1 cycle):
  - Clear indices and the pair counter.
  - If either latched count is 0, go to DRAIN with no pairs issued; otherwise go to ITER.
- ITER, each cycle:
  - If stall=1: hold addresses, issue strobe = 0.
  - Else issue the pair (inner_idx, outer_idx), issue strobe = 1, pair_cnt += 1.
  - If inner_idx = ni-1, set inner_idx = 0 and outer_idx += 1; otherwise inner_idx += 1.
  - Last pair: (inner_idx = ni-1 and outer_idx = no-1) or pair_cnt = MAX_PAIRS-1. The last pair is marked and the next state is DRAIN.
  - truncated = 1 if the budget ended the loop before the natural end.
- Addresses are registered outputs, stable for the cycle the strobe is high.
  - In IDLE/DRAIN addresses hold their last value; idx does not advance.
- DRAIN: wait LOOKUP_LAT cycles so the delay line empties, then pulse done[0] for 1 cycle and go to IDLE.
- Strobe/last path: a LOOKUP_LAT-deep shift register gives pair_valid/pair_last exactly LOOKUP_LAT cycles after the address cycle. stall does not freeze this pipeline.
- Counts are sampled only at start; changes mid-BX are ignored.
- Pair counter is 12 bits; with counts ≤63, ni×no ≤ 3969 fits.
- Simultaneous stall and last pair: the last pair is issued when stall drops.

Test Plan:
- Reset low, then high → bx = 31, all outputs 0. start[0] with ni=2, no=3 → bx=0; inner addresses 0,1,0,1,0,1 and outer 0,0,1,1,2,2 on 6 consecutive cycles. pair_valid 6 cycles starting 3 cycles after the first address. pair_last on the 6th. done[0] 3 cycles after the last issue; truncated=0.
- ni=0, no=5 → no pair_valid; done[0] fires LOAD+LOOKUP_LAT cycles after start; busy drops.
- ni=no=20, MAX_PAIRS=108 → exactly 108 pair_valid. Last pair is inner=7, outer=5; truncated=1 after DRAIN.
- ni=3, no=2, stall high on issue cycles 2–4 → 6 pairs still in correct order. Addresses held during stall; pair_valid has a 3-cycle gap; done delayed 3 cycles.
- start[0] re-asserted mid-ITER (ni=no=10) → overrun pulse; no done for the old BX; new BX restarts at idx 0 with bx+1; bx wraps 31→0 over 32 BXs.
- start[1] mid-ITER → next cycle state IDLE, bx=31, busy=0. done[1] = 1 one cycle after; done[0] never fires for the aborted BX.
